// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-wide RAM handshake and the arbiter FSM.
// The MIPS core imports the same mem_ctrl encodings so both sides agree.
package mem_arbiter_pkg;

    // mem_ctrl encodings used by every master and by the RAM
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_WR   = 2'b01;
    localparam logic [1:0] MEM_RD   = 2'b10;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10,
        GAP  = 2'b11
    } arb_state_t;

    // A master requests only with a real read or write; 2'b11 is ignored
    function automatic logic is_req(input logic [1:0] ctrl);
        return (ctrl == MEM_WR) || (ctrl == MEM_RD);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Ownership watchdog: counts owner cycles without a completed byte and
// flags the terminal count so the arbiter can revoke a hung grant.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,     // a master currently owns the RAM
    input  logic done,   // a byte completed this cycle
    output logic tc      // this is the last allowed idle cycle
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == LAST);

    // Count idle owner cycles; restart on completion, on terminal count and outside ownership
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (!en || done || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared byte-wide data RAM. Master 0 is the
// MIPS core, master 1 the loader/debug port. One owner at a time is routed
// to the RAM; the other sees a silent RAM and stalls. A one-cycle GAP
// separates owners so the RAM always observes idle between them.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [1:0]  m0_mem_ctrl,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_send,
    input  logic        m0_receive,
    output logic [7:0]  m0_rdata,
    output logic        m0_ram_send,
    output logic        m0_ram_receive,
    output logic        m0_grant,

    input  logic [1:0]  m1_mem_ctrl,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_send,
    input  logic        m1_receive,
    output logic [7:0]  m1_rdata,
    output logic        m1_ram_send,
    output logic        m1_ram_receive,
    output logic        m1_grant,

    output logic [1:0]  ram_mem_ctrl,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_cpu_send,
    output logic        ram_cpu_receive,
    input  logic [7:0]  ram_rdata,
    input  logic        ram_send,
    input  logic        ram_receive,

    output logic        timeout_err,
    output logic        timeout_id
);

    arb_state_t state;
    logic       last_owner;

    logic req0;
    logic req1;
    logic own;
    logic owner;
    logic done;
    logic release_own;
    logic tc;
    logic timeout;

    assign req0  = is_req(m0_mem_ctrl);
    assign req1  = is_req(m1_mem_ctrl);
    assign own   = (state == OWN0) || (state == OWN1);
    assign owner = (state == OWN1);

    assign m0_grant = (state == OWN0);
    assign m1_grant = (state == OWN1);

    // Route the owner's handshake to the RAM and the RAM's answers back to the owner only
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        ram_mem_ctrl    = MEM_IDLE;
        ram_addr        = '0;
        ram_wdata       = '0;
        ram_cpu_send    = 1'b0;
        ram_cpu_receive = 1'b0;
        m0_rdata        = '0;
        m0_ram_send     = 1'b0;
        m0_ram_receive  = 1'b0;
        m1_rdata        = '0;
        m1_ram_send     = 1'b0;
        m1_ram_receive  = 1'b0;
        case (state)
            OWN0: begin
                ram_mem_ctrl    = m0_mem_ctrl;
                ram_addr        = m0_addr;
                ram_wdata       = m0_wdata;
                ram_cpu_send    = m0_send;
                ram_cpu_receive = m0_receive;
                m0_rdata        = ram_rdata;
                m0_ram_send     = ram_send;
                m0_ram_receive  = ram_receive;
            end
            OWN1: begin
                ram_mem_ctrl    = m1_mem_ctrl;
                ram_addr        = m1_addr;
                ram_wdata       = m1_wdata;
                ram_cpu_send    = m1_send;
                ram_cpu_receive = m1_receive;
                m1_rdata        = ram_rdata;
                m1_ram_send     = ram_send;
                m1_ram_receive  = ram_receive;
            end
            default: ;
        endcase
    end

    // A byte completes when either direction's strobe pair meets at the RAM
    assign done        = (ram_send & ram_cpu_receive) | (ram_cpu_send & ram_receive);
    assign release_own = own && (ram_mem_ctrl == MEM_IDLE);
    // A release in the terminal cycle wins over revocation
    assign timeout     = tc && !done && !release_own;
    assign timeout_err = timeout;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .en   (own),
        .done (done),
        .tc   (tc)
    );

    // Ownership FSM: grant on request, hold through multi-byte sequences, always pass through GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            timeout_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        // Round-robin picks the master that did not own last
                        state <= ((FIXED_PRIO != 0) || last_owner) ? OWN0 : OWN1;
                    end else if (req0) begin
                        state <= OWN0;
                    end else if (req1) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (release_own) begin
                        state      <= GAP;
                        last_owner <= owner;
                    end else if (timeout) begin
                        state      <= GAP;
                        last_owner <= owner;
                        timeout_id <= owner;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share one stimulus set:
// dut_a is round-robin, dut_b is fixed priority; both use TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are checked
// one further unit later, well away from the next edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  m0_mem_ctrl, m1_mem_ctrl;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_send, m0_receive, m1_send, m1_receive;
    logic [7:0]  ram_rdata;
    logic        ram_send, ram_receive;

    logic [7:0]  a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
    logic        a_m0_ram_send, a_m0_ram_receive, a_m0_grant;
    logic        a_m1_ram_send, a_m1_ram_receive, a_m1_grant;
    logic        b_m0_ram_send, b_m0_ram_receive, b_m0_grant;
    logic        b_m1_ram_send, b_m1_ram_receive, b_m1_grant;
    logic [1:0]  a_ram_mem_ctrl, b_ram_mem_ctrl;
    logic [15:0] a_ram_addr, b_ram_addr;
    logic [7:0]  a_ram_wdata, b_ram_wdata;
    logic        a_ram_cpu_send, a_ram_cpu_receive, b_ram_cpu_send, b_ram_cpu_receive;
    logic        a_timeout_err, a_timeout_id, b_timeout_err, b_timeout_id;

    logic [51:0] a_all, b_all;
    logic [10:0] a_m1_ret;
    assign a_all = {a_m0_rdata, a_m0_ram_send, a_m0_ram_receive, a_m0_grant,
                    a_m1_rdata, a_m1_ram_send, a_m1_ram_receive, a_m1_grant,
                    a_ram_mem_ctrl, a_ram_addr, a_ram_wdata, a_ram_cpu_send,
                    a_ram_cpu_receive, a_timeout_err, a_timeout_id};
    assign b_all = {b_m0_rdata, b_m0_ram_send, b_m0_ram_receive, b_m0_grant,
                    b_m1_rdata, b_m1_ram_send, b_m1_ram_receive, b_m1_grant,
                    b_ram_mem_ctrl, b_ram_addr, b_ram_wdata, b_ram_cpu_send,
                    b_ram_cpu_receive, b_timeout_err, b_timeout_id};
    assign a_m1_ret = {a_m1_rdata, a_m1_ram_send, a_m1_ram_receive, a_m1_grant};

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .m0_mem_ctrl(m0_mem_ctrl), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_send(m0_send), .m0_receive(m0_receive), .m0_rdata(a_m0_rdata),
        .m0_ram_send(a_m0_ram_send), .m0_ram_receive(a_m0_ram_receive), .m0_grant(a_m0_grant),
        .m1_mem_ctrl(m1_mem_ctrl), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_send(m1_send), .m1_receive(m1_receive), .m1_rdata(a_m1_rdata),
        .m1_ram_send(a_m1_ram_send), .m1_ram_receive(a_m1_ram_receive), .m1_grant(a_m1_grant),
        .ram_mem_ctrl(a_ram_mem_ctrl), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_cpu_send(a_ram_cpu_send), .ram_cpu_receive(a_ram_cpu_receive),
        .ram_rdata(ram_rdata), .ram_send(ram_send), .ram_receive(ram_receive),
        .timeout_err(a_timeout_err), .timeout_id(a_timeout_id)
    );

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .m0_mem_ctrl(m0_mem_ctrl), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_send(m0_send), .m0_receive(m0_receive), .m0_rdata(b_m0_rdata),
        .m0_ram_send(b_m0_ram_send), .m0_ram_receive(b_m0_ram_receive), .m0_grant(b_m0_grant),
        .m1_mem_ctrl(m1_mem_ctrl), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_send(m1_send), .m1_receive(m1_receive), .m1_rdata(b_m1_rdata),
        .m1_ram_send(b_m1_ram_send), .m1_ram_receive(b_m1_ram_receive), .m1_grant(b_m1_grant),
        .ram_mem_ctrl(b_ram_mem_ctrl), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_cpu_send(b_ram_cpu_send), .ram_cpu_receive(b_ram_cpu_receive),
        .ram_rdata(ram_rdata), .ram_send(ram_send), .ram_receive(ram_receive),
        .timeout_err(b_timeout_err), .timeout_id(b_timeout_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_mem_ctrl = 2'b00; m0_addr = '0; m0_wdata = '0; m0_send = 0; m0_receive = 0;
        m1_mem_ctrl = 2'b00; m1_addr = '0; m1_wdata = '0; m1_send = 0; m1_receive = 0;
        ram_rdata = '0; ram_send = 0; ram_receive = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (a_all !== 52'd0) begin errors++; $display("FAIL reset_a_outputs got %h want 0", a_all); end
        checks++; if (b_all !== 52'd0) begin errors++; $display("FAIL reset_b_outputs got %h want 0", b_all); end
        m0_mem_ctrl = 2'b10;
        tick();
        #1;
        checks++; if (a_all !== 52'd0) begin errors++; $display("FAIL reset_held_req got %h want 0", a_all); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_read();
        do_reset();
        m0_mem_ctrl = 2'b10; m0_addr = 16'h0010;
        #1;
        checks++; if (a_m0_grant !== 1'b0) begin errors++; $display("FAIL rd_grant_early got %b want 0", a_m0_grant); end
        tick();
        checks++; if (a_m0_grant !== 1'b1) begin errors++; $display("FAIL rd_grant got %b want 1", a_m0_grant); end
        checks++; if (a_ram_mem_ctrl !== 2'b10) begin errors++; $display("FAIL rd_ram_ctrl got %b want 10", a_ram_mem_ctrl); end
        checks++; if (a_ram_addr !== 16'h0010) begin errors++; $display("FAIL rd_ram_addr got %h want 0010", a_ram_addr); end
        ram_rdata = 8'hAB; ram_send = 1; m0_receive = 1;
        #1;
        checks++; if (a_m0_rdata !== 8'hAB) begin errors++; $display("FAIL rd_rdata got %h want ab", a_m0_rdata); end
        checks++; if (a_m0_ram_send !== 1'b1) begin errors++; $display("FAIL rd_ram_send got %b want 1", a_m0_ram_send); end
        checks++; if (a_ram_cpu_receive !== 1'b1) begin errors++; $display("FAIL rd_cpu_receive got %b want 1", a_ram_cpu_receive); end
        checks++; if (a_m1_ret !== 11'd0) begin errors++; $display("FAIL rd_m1_stalled got %h want 0", a_m1_ret); end
        tick();
        idle_inputs();
        tick();
        checks++; if ({a_m0_grant, a_m1_grant, a_ram_mem_ctrl} !== 4'b0) begin errors++;
            $display("FAIL rd_gap got %b want 0000", {a_m0_grant, a_m1_grant, a_ram_mem_ctrl}); end
        tick();
    endtask

    task automatic test_arbitration();
        do_reset();
        m0_mem_ctrl = 2'b10; m1_mem_ctrl = 2'b10; m0_addr = 16'h0020; m1_addr = 16'h0030;
        tick();
        checks++; if ({a_m0_grant, a_m1_grant} !== 2'b10) begin errors++; $display("FAIL tie_rr_first got %b want 10", {a_m0_grant, a_m1_grant}); end
        checks++; if ({b_m0_grant, b_m1_grant} !== 2'b10) begin errors++; $display("FAIL tie_fp_first got %b want 10", {b_m0_grant, b_m1_grant}); end
        m0_mem_ctrl = 2'b00;
        tick();
        checks++; if ({a_m0_grant, a_m1_grant, a_ram_mem_ctrl} !== 4'b0) begin errors++;
            $display("FAIL tie_gap_a got %b want 0000", {a_m0_grant, a_m1_grant, a_ram_mem_ctrl}); end
        checks++; if ({b_m0_grant, b_m1_grant, b_ram_mem_ctrl} !== 4'b0) begin errors++;
            $display("FAIL tie_gap_b got %b want 0000", {b_m0_grant, b_m1_grant, b_ram_mem_ctrl}); end
        m0_mem_ctrl = 2'b10;
        tick();
        checks++; if ({a_m0_grant, a_m1_grant} !== 2'b00) begin errors++; $display("FAIL tie_idle got %b want 00", {a_m0_grant, a_m1_grant}); end
        tick();
        checks++; if ({a_m0_grant, a_m1_grant} !== 2'b01) begin errors++; $display("FAIL tie_rr_second got %b want 01", {a_m0_grant, a_m1_grant}); end
        checks++; if (a_ram_addr !== 16'h0030) begin errors++; $display("FAIL tie_rr_addr got %h want 0030", a_ram_addr); end
        checks++; if ({b_m0_grant, b_m1_grant} !== 2'b10) begin errors++; $display("FAIL tie_fp_second got %b want 10", {b_m0_grant, b_m1_grant}); end
        checks++; if (b_ram_addr !== 16'h0020) begin errors++; $display("FAIL tie_fp_addr got %h want 0020", b_ram_addr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [2];
        logic [7:0]  datas [2];
        addrs[0] = 16'h0100; addrs[1] = 16'h0101;
        datas[0] = 8'h5A;    datas[1] = 8'hA5;
        do_reset();
        m1_mem_ctrl = 2'b01; m1_addr = addrs[0]; m1_wdata = datas[0];
        tick();
        for (int i = 0; i < 2; i++) begin
            m1_addr = addrs[i]; m1_wdata = datas[i]; m1_send = 1; ram_receive = 1;
            #1;
            checks++; if (a_m1_grant !== 1'b1) begin errors++; $display("FAIL b2b_grant[%0d] got %b want 1", i, a_m1_grant); end
            checks++; if ({a_ram_mem_ctrl, a_ram_addr, a_ram_wdata} !== {2'b01, addrs[i], datas[i]}) begin errors++;
                $display("FAIL b2b_route[%0d] got %b/%h/%h want 01/%h/%h", i, a_ram_mem_ctrl, a_ram_addr, a_ram_wdata, addrs[i], datas[i]); end
            checks++; if ({a_m1_ram_receive, a_ram_cpu_send} !== 2'b11) begin errors++;
                $display("FAIL b2b_strobes[%0d] got %b want 11", i, {a_m1_ram_receive, a_ram_cpu_send}); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (a_m1_grant !== 1'b1) begin errors++; $display("FAIL b2b_hold_release got %b want 1", a_m1_grant); end
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        m0_mem_ctrl = 2'b10; m1_mem_ctrl = 2'b01; m1_addr = 16'h0200;
        tick();
        repeat (7) begin
            checks++; if ({a_m0_grant, a_timeout_err} !== 2'b10) begin errors++;
                $display("FAIL wd_wait got %b want 10", {a_m0_grant, a_timeout_err}); end
            tick();
        end
        checks++; if ({a_m0_grant, a_timeout_err} !== 2'b11) begin errors++; $display("FAIL wd_pulse0 got %b want 11", {a_m0_grant, a_timeout_err}); end
        tick();
        checks++; if ({a_m0_grant, a_m1_grant, a_timeout_err, a_timeout_id} !== 4'b0) begin errors++;
            $display("FAIL wd_gap0 got %b want 0000", {a_m0_grant, a_m1_grant, a_timeout_err, a_timeout_id}); end
        tick();
        tick();
        checks++; if ({a_m0_grant, a_m1_grant} !== 2'b01) begin errors++; $display("FAIL wd_m1_granted got %b want 01", {a_m0_grant, a_m1_grant}); end
        checks++; if (b_m0_grant !== 1'b1) begin errors++; $display("FAIL wd_fp_regrant got %b want 1", b_m0_grant); end
        repeat (7) tick();
        checks++; if (a_timeout_err !== 1'b1) begin errors++; $display("FAIL wd_pulse1 got %b want 1", a_timeout_err); end
        checks++; if (b_timeout_err !== 1'b1) begin errors++; $display("FAIL wd_fp_pulse got %b want 1", b_timeout_err); end
        tick();
        checks++; if ({a_timeout_err, a_timeout_id} !== 2'b01) begin errors++; $display("FAIL wd_id1 got %b want 01", {a_timeout_err, a_timeout_id}); end
        checks++; if (b_timeout_id !== 1'b0) begin errors++; $display("FAIL wd_fp_id got %b want 0", b_timeout_id); end
    endtask

    task automatic test_release_at_timeout();
        do_reset();
        m0_mem_ctrl = 2'b10;
        tick();
        repeat (6) tick();
        ram_send = 1; m0_receive = 1;
        tick();
        ram_send = 0; m0_receive = 0;
        #1;
        checks++; if (a_timeout_err !== 1'b0) begin errors++; $display("FAIL wd_cleared got %b want 0", a_timeout_err); end
        repeat (7) tick();
        checks++; if (a_timeout_err !== 1'b1) begin errors++; $display("FAIL wd_after_clear got %b want 1", a_timeout_err); end
        m0_mem_ctrl = 2'b00;
        #1;
        checks++; if (a_timeout_err !== 1'b0) begin errors++; $display("FAIL rel_wins got %b want 0", a_timeout_err); end
        tick();
        checks++; if ({a_m0_grant, a_timeout_err, a_timeout_id} !== 3'b0) begin errors++;
            $display("FAIL rel_gap got %b want 000", {a_m0_grant, a_timeout_err, a_timeout_id}); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_mem_ctrl = 2'b10; m0_addr = 16'h0040;
        tick();
        checks++; if (a_m0_grant !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", a_m0_grant); end
        ram_send = 1; ram_rdata = 8'h77;
        rst = 1'b1;
        tick();
        ram_send = 0; ram_rdata = 8'h00;
        #1;
        checks++; if (a_all !== 52'd0) begin errors++; $display("FAIL rst_mid_abort got %h want 0", a_all); end
        rst = 1'b0;
        #1;
        checks++; if (a_m0_grant !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b want 0", a_m0_grant); end
        tick();
        checks++; if ({a_m0_grant, a_ram_addr} !== {1'b1, 16'h0040}) begin errors++;
            $display("FAIL rst_mid_regrant got %b/%h want 1/0040", a_m0_grant, a_ram_addr); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_read();
        test_arbitration();
        test_back_to_back();
        test_watchdog();
        test_release_at_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
